// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants, converter FSM state type and digit check
//
// Purpose : common definitions for the BCD <-> binary converter family.
// Contents: BCD_DIGIT_W, BCD_MAX_DIGIT, bcd_state_e, bcd_digit_valid().
package bcd_pkg;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BCD_MAX_DIGIT = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } bcd_state_e;

  function automatic logic bcd_digit_valid(input logic [BCD_DIGIT_W-1:0] nibble);
    return nibble <= BCD_DIGIT_W'(BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// rtl/bcd_mac10.sv - combinational multiply-by-ten-and-add step for BCD conversion
//
// Purpose : o_result = i_acc*10 + i_digit, built from shifts and adds.
// Ports   : i_acc    - W-bit running accumulator
//           i_digit  - one BCD nibble (not range-checked here)
//           o_result - W-bit result, wraps modulo 2^W
module bcd_mac10 import bcd_pkg::*; #(
  parameter int W = 14
) (
  input  logic [W-1:0]           i_acc,
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [W-1:0]           o_result
);

  // acc*10 == acc*8 + acc*2
  assign o_result = (i_acc << 3) + (i_acc << 1) + W'(i_digit);

endmodule

// File: rtl/bcd3_to_binary_seq.sv
// rtl/bcd3_to_binary_seq.sv - sequential packed-BCD to unsigned binary converter
//
// Purpose : accepts NUM_DIGITS packed BCD digits through a valid/ready handshake,
//           folds them MSD first into a binary accumulator one digit per cycle,
//           and presents the result through a valid/ready handshake.
// Ports   : clk, resetN (async, active low)
//           inValid/inReady/bcdIn          - input word handshake
//           outValid/outReady/binaryOut    - result handshake
//           digitError                     - some input nibble was above 9
module bcd3_to_binary_seq import bcd_pkg::*; #(
  parameter int NUM_DIGITS = 3,
  parameter int OUT_WIDTH  = 10
) (
  input  logic                              clk,
  input  logic                              resetN,
  input  logic                              inValid,
  output logic                              inReady,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] bcdIn,
  output logic                              outValid,
  input  logic                              outReady,
  output logic [OUT_WIDTH-1:0]              binaryOut,
  output logic                              digitError
);

  localparam int ACC_W = OUT_WIDTH + BCD_DIGIT_W;
  localparam int IN_W  = BCD_DIGIT_W * NUM_DIGITS;
  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  bcd_state_e              r_state;
  logic [IN_W-1:0]         r_shadow;
  logic [ACC_W-1:0]        r_acc;
  logic [CNT_W-1:0]        r_digit_cnt;
  logic                    r_err;

  logic [BCD_DIGIT_W-1:0]  w_digit;
  logic [ACC_W-1:0]        w_acc_next;
  logic                    w_overflow;
  logic                    w_bad;

  // The shadow word is shifted left one digit per CONV cycle, so the digit
  // being folded in is always the top nibble (MSD first).
  assign w_digit = r_shadow[IN_W-1 -: BCD_DIGIT_W];

  bcd_mac10 #(.W(ACC_W)) u_mac10 (
    .i_acc    (r_acc),
    .i_digit  (w_digit),
    .o_result (w_acc_next)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= ST_IDLE;
      r_shadow    <= '0;
      r_acc       <= '0;
      r_digit_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (inValid) begin
            r_shadow    <= bcdIn;
            r_acc       <= '0;
            r_err       <= 1'b0;
            r_digit_cnt <= '0;
            r_state     <= ST_CONV;
          end
        end
        ST_CONV: begin
          r_acc       <= w_acc_next;
          r_shadow    <= r_shadow << BCD_DIGIT_W;
          r_digit_cnt <= r_digit_cnt + CNT_W'(1);
          if (!bcd_digit_valid(w_digit)) begin
            r_err <= 1'b1;
          end
          if (r_digit_cnt == LAST_DIGIT) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (outReady) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // With all digits valid the accumulator never exceeds 10^NUM_DIGITS-1, so
  // any bit above OUT_WIDTH can only come from bad nibbles; treat it as one.
  assign w_overflow = |r_acc[ACC_W-1:OUT_WIDTH];
  assign w_bad      = r_err || w_overflow;

  assign inReady    = (r_state == ST_IDLE);
  assign outValid   = (r_state == ST_DONE);
  assign digitError = outValid && w_bad;
  assign binaryOut  = (outValid && !w_bad) ? r_acc[OUT_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_bcd3_to_binary_seq.sv
// tb/tb_bcd3_to_binary_seq.sv - self-checking bench for bcd3_to_binary_seq
module tb_bcd3_to_binary_seq;

  typedef struct {
    logic [9:0] val;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetN;
  logic        inValid;
  logic        inReady;
  logic [11:0] bcdIn;
  logic        outValid;
  logic        outReady;
  logic [9:0]  binaryOut;
  logic        digitError;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bcd3_to_binary_seq #(.NUM_DIGITS(3), .OUT_WIDTH(10)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .inValid    (inValid),
    .inReady    (inReady),
    .bcdIn      (bcdIn),
    .outValid   (outValid),
    .outReady   (outReady),
    .binaryOut  (binaryOut),
    .digitError (digitError)
  );

  function automatic exp_t model(input logic [11:0] w);
    exp_t       e;
    int         acc;
    logic [3:0] d;
    acc   = 0;
    e.err = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      d = w[4*i +: 4];
      if (d > 4'd9) e.err = 1'b1;
      acc = acc * 10 + int'(d);
    end
    e.val = e.err ? 10'd0 : 10'(acc);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word, wait for it to be accepted, push its expected result.
  task automatic send(input logic [11:0] w, output bit ok);
    int n;
    n = 0;
    while (!inReady && n < 20) begin
      step();
      n++;
    end
    ok = inReady;
    if (ok) begin
      inValid = 1'b1;
      bcdIn   = w;
      sb.push_back(model(w));
      step();
      inValid = 1'b0;
    end
  endtask

  task automatic wait_out(output bit ok);
    int n;
    n = 0;
    while (!outValid && n < 20) begin
      step();
      n++;
    end
    ok = outValid;
  endtask

  task automatic test_reset();
    resetN   = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b1;
    bcdIn    = '0;
    step();
    step();
    n_vec++; if (inReady !== 1'b1)      begin n_err++; $display("FAIL reset_inReady got %b want 1", inReady); end
    n_vec++; if (outValid !== 1'b0)     begin n_err++; $display("FAIL reset_outValid got %b want 0", outValid); end
    n_vec++; if (binaryOut !== 10'd0)   begin n_err++; $display("FAIL reset_binaryOut got %0d want 0", binaryOut); end
    n_vec++; if (digitError !== 1'b0)   begin n_err++; $display("FAIL reset_digitError got %b want 0", digitError); end
    resetN = 1'b1;
    step();
  endtask

  task automatic test_latency();
    exp_t e;
    outReady = 1'b1;
    inValid  = 1'b1;
    bcdIn    = 12'h127;
    sb.push_back(model(12'h127));
    step();
    inValid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      n_vec++; if (outValid !== 1'b0 || inReady !== 1'b0) begin
        n_err++; $display("FAIL latency_cycle%0d outValid=%b inReady=%b want 0 0", c, outValid, inReady);
      end
      step();
    end
    n_vec++; if (outValid !== 1'b1 || inReady !== 1'b0) begin
      n_err++; $display("FAIL latency_cycle4 outValid=%b inReady=%b want 1 0", outValid, inReady);
    end
    e = sb.pop_front();
    n_vec++; if (binaryOut !== e.val || digitError !== e.err) begin
      n_err++; $display("FAIL latency_127 got %0d/%b want %0d/%b", binaryOut, digitError, e.val, e.err);
    end
    step();
    n_vec++; if (inReady !== 1'b1 || outValid !== 1'b0 || binaryOut !== 10'd0) begin
      n_err++; $display("FAIL latency_idle inReady=%b outValid=%b binaryOut=%0d want 1 0 0", inReady, outValid, binaryOut);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] words[4];
    int          acc_cyc[4];
    int          idx, got, cyc;
    bit          acc_now;
    exp_t        e;
    words   = '{12'h000, 12'h999, 12'h042, 12'h500};
    idx     = 0;
    got     = 0;
    cyc     = 0;
    outReady = 1'b1;
    inValid  = 1'b1;
    bcdIn    = words[0];
    while (got < 4 && cyc < 60) begin
      if (outValid) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL b2b_unexpected_output got %0d want none", binaryOut);
        end else begin
          e = sb.pop_front();
          if (binaryOut !== e.val || digitError !== e.err) begin
            n_err++; $display("FAIL b2b_result%0d got %0d/%b want %0d/%b", got, binaryOut, digitError, e.val, e.err);
          end
        end
        got++;
      end
      acc_now = inReady && inValid;
      if (acc_now) begin
        sb.push_back(model(bcdIn));
        acc_cyc[idx] = cyc;
      end
      step();
      cyc++;
      if (acc_now) begin
        idx++;
        if (idx < 4) bcdIn = words[idx];
        else inValid = 1'b0;
      end
    end
    n_vec++; if (got !== 4) begin n_err++; $display("FAIL b2b_count got %0d want 4", got); end
    for (int i = 1; i < 4; i++) begin
      n_vec++; if (acc_cyc[i] - acc_cyc[i-1] !== 5) begin
        n_err++; $display("FAIL b2b_period%0d got %0d want 5", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    inValid = 1'b0;
    step();
  endtask

  task automatic test_invalid_digit();
    bit   ok;
    exp_t e;
    outReady = 1'b1;
    send(12'h1A3, ok);
    wait_out(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL invalid_timeout outValid=%b want 1", outValid); end
    e = sb.pop_front();
    n_vec++; if (binaryOut !== e.val || digitError !== e.err || e.err !== 1'b1) begin
      n_err++; $display("FAIL invalid_1A3 got %0d/%b want %0d/%b", binaryOut, digitError, e.val, e.err);
    end
    step();
    send(12'h042, ok);
    wait_out(ok);
    e = sb.pop_front();
    n_vec++; if (!ok || binaryOut !== e.val || digitError !== e.err) begin
      n_err++; $display("FAIL invalid_next_042 got %0d/%b want %0d/%b", binaryOut, digitError, e.val, e.err);
    end
    step();
  endtask

  task automatic test_backpressure();
    bit   ok;
    exp_t e;
    outReady = 1'b0;
    send(12'h505, ok);
    wait_out(ok);
    e = sb.pop_front();
    for (int c = 0; c < 6; c++) begin
      n_vec++; if (outValid !== 1'b1 || binaryOut !== e.val || inReady !== 1'b0) begin
        n_err++; $display("FAIL backpressure_hold%0d outValid=%b binaryOut=%0d inReady=%b want 1 %0d 0", c, outValid, binaryOut, inReady, e.val);
      end
      step();
    end
    outReady = 1'b1;
    step();
    n_vec++; if (inReady !== 1'b1 || outValid !== 1'b0) begin
      n_err++; $display("FAIL backpressure_release inReady=%b outValid=%b want 1 0", inReady, outValid);
    end
  endtask

  task automatic test_input_change();
    bit   ok;
    exp_t e;
    outReady = 1'b1;
    send(12'h321, ok);
    bcdIn = 12'h888;
    wait_out(ok);
    e = sb.pop_front();
    n_vec++; if (!ok || binaryOut !== e.val || digitError !== e.err) begin
      n_err++; $display("FAIL input_change got %0d/%b want %0d/%b", binaryOut, digitError, e.val, e.err);
    end
    step();
  endtask

  task automatic test_reset_mid_conv();
    bit   ok;
    bit   seen;
    exp_t e;
    outReady = 1'b1;
    send(12'h777, ok);
    step();
    #2;
    resetN = 1'b0;
    #1;
    n_vec++; if (inReady !== 1'b1 || outValid !== 1'b0 || binaryOut !== 10'd0 || digitError !== 1'b0) begin
      n_err++; $display("FAIL midreset_outputs inReady=%b outValid=%b binaryOut=%0d digitError=%b want 1 0 0 0", inReady, outValid, binaryOut, digitError);
    end
    sb.delete();
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (outValid) seen = 1'b1;
    end
    resetN = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      if (outValid) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL midreset_no_outValid got %b want 0", seen); end
    send(12'h010, ok);
    wait_out(ok);
    e = sb.pop_front();
    n_vec++; if (!ok || binaryOut !== e.val || digitError !== e.err) begin
      n_err++; $display("FAIL midreset_010 got %0d/%b want %0d/%b", binaryOut, digitError, e.val, e.err);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_invalid_digit();
    test_backpressure();
    test_input_change();
    test_reset_mid_conv();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
